// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake plus ALU issue/result bus between the decode stage and the ALU.
// slave = issue controller, master = upstream instruction source together with the ALU.
interface alu_issue_ctrl_if;
    logic        instr_valid;
    logic [19:0] instr;
    logic        instr_ready;
    logic        alu_start;
    logic [5:0]  alu_op;
    logic        alu_mode;
    logic [19:0] alu_a;
    logic [19:0] alu_b;
    logic        alu_done;
    logic [19:0] alu_result;
    logic [19:0] alu_result_b;
    logic        alu_zero;
    logic        alu_sign;
    logic        alu_carry;

    modport master (
        output instr_valid, instr, alu_done, alu_result, alu_result_b,
               alu_zero, alu_sign, alu_carry,
        input  instr_ready, alu_start, alu_op, alu_mode, alu_a, alu_b
    );

    modport slave (
        input  instr_valid, instr, alu_done, alu_result, alu_result_b,
               alu_zero, alu_sign, alu_carry,
        output instr_ready, alu_start, alu_op, alu_mode, alu_a, alu_b
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Decode/issue stage: register file, ALU issue/writeback, status and trap mode.
// ALU op: ready again 4 cycles after accept (1-cycle done); local op: 2; instr_ready low while busy.
module alu_issue_ctrl #(
    parameter int NREGS   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    alu_issue_ctrl_if.slave          bus,
    output logic [12:0]              status_o,
    input  logic                     rf_wr_en_i,
    input  logic [$clog2(NREGS)-1:0] rf_wr_addr_i,
    input  logic [19:0]              rf_wr_data_i,
    input  logic [$clog2(NREGS)-1:0] rf_rd_addr_i,
    output logic [19:0]              rf_rd_data_o
);
    localparam int IW = $clog2(NREGS);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EXEC, S_WB} state_e;

    state_e          state_q;
    logic            ready_q, start_q, mode_q;
    logic [5:0]      op_q;
    logic [IW-1:0]   rd_q, rb_q;
    logic [19:0]     a_q, b_q, res_q, res_b_q;
    logic [2:0]      cap_flags_q;
    logic [2:0]      flags_q;
    logic            trap_q, illegal_q, timeout_q;
    logic [CW-1:0]   cnt_q;
    logic [19:0]     rf_q [NREGS];
    logic [12:0]     status_w;
    logic            unused_bits;

    function automatic logic is_alu_op(input logic [5:0] op);
        return (op >= 6'h10 && op <= 6'h13) || (op >= 6'h20 && op <= 6'h24) ||
               (op >= 6'h30 && op <= 6'h35) || (op >= 6'h38 && op <= 6'h3C);
    endfunction

    function automatic logic is_cmp_op(input logic [5:0] op);
        return (op >= 6'h38 && op <= 6'h3C);
    endfunction

    assign status_w        = {6'b0, timeout_q, illegal_q, mode_q, trap_q, flags_q};
    assign status_o        = status_w;
    assign rf_rd_data_o    = rf_q[rf_rd_addr_i];
    assign unused_bits     = ^bus.instr[6:0];

    assign bus.instr_ready = ready_q;
    assign bus.alu_start   = start_q;
    assign bus.alu_op      = op_q;
    assign bus.alu_mode    = mode_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            start_q     <= 1'b0;
            mode_q      <= 1'b0;
            op_q        <= '0;
            rd_q        <= '0;
            rb_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            res_b_q     <= '0;
            cap_flags_q <= '0;
            flags_q     <= '0;
            trap_q      <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // An accepted instruction takes priority; a coincident external load is dropped.
                    if (bus.instr_valid) begin
                        op_q    <= bus.instr[19:14];
                        mode_q  <= bus.instr[13];
                        rd_q    <= bus.instr[12:10];
                        rb_q    <= bus.instr[9:7];
                        a_q     <= rf_q[bus.instr[12:10]];
                        b_q     <= rf_q[bus.instr[9:7]];
                        ready_q <= 1'b0;
                        if (is_alu_op(bus.instr[19:14])) begin
                            state_q <= S_ISSUE;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= S_WB;
                        end
                    end else if (rf_wr_en_i) begin
                        rf_q[rf_wr_addr_i] <= rf_wr_data_i;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_EXEC;
                    cnt_q   <= '0;
                end
                S_EXEC: begin
                    if (bus.alu_done) begin
                        res_q       <= bus.alu_result;
                        res_b_q     <= bus.alu_result_b;
                        cap_flags_q <= {bus.alu_carry, bus.alu_sign, bus.alu_zero};
                        state_q     <= S_WB;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                        ready_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WB: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    if (is_alu_op(op_q)) begin
                        flags_q <= cap_flags_q;
                        // For SWAP the rd write comes last so it wins when rd == rb.
                        if (op_q == 6'h24) begin
                            rf_q[rb_q] <= res_b_q;
                            rf_q[rd_q] <= res_q;
                        end else if (!is_cmp_op(op_q)) begin
                            rf_q[rd_q] <= res_q;
                        end
                    end else begin
                        case (op_q)
                            6'h00:  trap_q <= 1'b1;
                            6'h3F:  trap_q <= 1'b0;
                            6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06: ;
                            6'h07:  rf_q[rd_q] <= {7'b0, status_w};
                            6'h08:  rf_q[rd_q] <= trap_q ? (rf_q[rd_q] ^ {7'b0, status_w}) : 20'h0;
                            default: illegal_q <= 1'b1;
                        endcase
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Decode/issue stage directly upstream of the ALU operation circuits. It accepts one 20-bit instruction per handshake and reads operands from an internal 8x20 register file. It issues one operation to the ALU, waits for completion, writes results back, and maintains the 13-bit status register consumed by LSTAT/XSTAT and the jump circuits. It also owns trap-mode entry and exit.

Parameters:
NREGS, 8, general registers (index width 3).
TIMEOUT, 15, max cycles in EXEC waiting for alu_done before abort.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction offered
instr  in  20  [19:14] opcode, [13] mode (1 full / 0 half), [12:10] rd (also operand A), [9:7] rb (operand B), [6:0] ignored
instr_ready  out  1  stage can accept
alu_start  out  1  one-cycle issue pulse
alu_op  out  6  opcode held from accept through WB
alu_mode  out  1  mode held from accept through WB
alu_a  out  20  operand A (reg[rd]), held
alu_b  out  20  operand B (reg[rb]), held
alu_done  in  1  ALU result valid (single cycle)
alu_result  in  20  primary result
alu_result_b  in  20  second result (SWAP out_b)
alu_zero, alu_sign, alu_carry  in  1 each  ALU flags
status  out  13  [0] zero, [1] sign, [2] carry, [3] trap, [4] mode, [5] illegal (sticky), [6] timeout (sticky), [12:7] always 0
rf_wr_en  in  1  external register load (IDLE only)
rf_wr_addr  in  3  load index
rf_wr_data  in  20  load data
rf_rd_addr  in  3  debug read index
rf_rd_data  out  20  combinational reg[rf_rd_addr]

Behaviour:
- Reset: state IDLE; all registers, status, alu_* outputs = 0; instr_ready = 1 after reset deasserts. Reset mid-operation aborts with no writeback.
- States: IDLE, ISSUE, EXEC, WB.
- IDLE: instr_ready = 1. On instr_valid: latch opcode/mode/rd/rb, load alu_a/alu_b from the register file, set status[4] = mode.
  - Local ops go to WB.
  - ALU ops go to ISSUE.
  - rf_wr_en is honoured only in IDLE and only when no instruction is accepted that cycle. Instruction acceptance wins, and the ignored load is dropped.
- Local ops (no ALU):
  - 0x00 TRAP: status[3] = 1.
  - 0x3F TRAPX: status[3] = 0.
  - 0x01 NOP and 0x02–0x06 jumps: no effect here.
  - 0x07 LSTAT: reg[rd] = {7'b0, status}.
  - 0x08 XSTAT: reg[rd] = reg[rd] ^ {7'b0, status} when trap = 1, else reg[rd] = 0.
  - Any undefined opcode: status[5] = 1, treated as NOP.
- ALU ops:
  - Logic 0x10–0x13.
  - Shift/rotate 0x20–0x23; SWAP 0x24.
  - Arith 0x30–0x35.
  - Compare 0x38–0x3C.
- ISSUE: alu_start = 1 for exactly one cycle, then EXEC.
- EXEC: wait for alu_done.
  - On done: capture result and flags, go to WB.
  - After TIMEOUT cycles without done: status[6] = 1, no writeback, no flag update, return to IDLE.
  - alu_done outside EXEC is ignored.
- WB (one cycle):
  - Flags: status[0..2] = captured alu_zero/sign/carry for every ALU op.
  - Logic/shift/arith: reg[rd] = alu_result.
  - SWAP: reg[rb] = alu_result_b, then reg[rd] = alu_result. If rd == rb, alu_result wins.
  - Compare ops: flags only, no register write.
  - Then IDLE.
- Latency: accept to instr_ready high again is 4 cycles for an ALU op with 1-cycle done (accept, ISSUE, EXEC, WB); 2 cycles for local ops.
- instr_ready = 0 in ISSUE, EXEC and WB.
- alu_op, alu_mode, alu_a and alu_b are stable from the cycle after accept until leaving WB.

Test Plan:
1. Reset mid-EXEC with reg[1] = 0x12345 -> all regs 0, status = 0, instr_ready = 1, alu_start = 0.
2. Load reg[1] = 0x0F0F0 and reg[2] = 0x00FF0; issue AND (0x11, full, rd = 1, rb = 2); model returns 0x000F0 with zero = 0 after 1 cycle -> alu_start pulses once with a = 0x0F0F0, b = 0x00FF0; reg[1] = 0x000F0; ready again 4 cycles after accept.
3. TRAP, then XSTAT rd = 3 with reg[3] = 0xFFFFF and status = 0x018 -> reg[3] = 0xFFFE7. Then TRAPX, XSTAT again -> reg[3] = 0, status[3] = 0.
4. SWAP rd = 4, rb = 5, with result = 0xAAAAA and result_b = 0x55555 -> reg[4] = 0xAAAAA, reg[5] = 0x55555. Repeat with rd = rb = 6 -> reg[6] = 0xAAAAA.
5. ALU op with alu_done never asserted -> after 15 EXEC cycles status[6] = 1, target register unchanged, instr_ready = 1.
6. Opcode 0x15 -> status[5] = 1 with no ALU issue. Then compare 0x38 with alu_zero = 1 -> status[0] = 1, no register changed. rf_wr_en asserted during EXEC -> ignored.
